approx_mul_pipe: RTL and testbench

Parametrised, pipelined successor to the team's 8x8 approximate compressor-tree multiplier. It multiplies two unsigned WIDTH-bit operands in either exact or approximate mode, selected per transaction. Operands enter and products leave through valid/ready handshakes, and the block counts completed approximate transactions. It sits between the operand-fetch stage and the accumulator in the approximate datapath.

---
 rtl/approx_mul_pkg.sv | 64 ++++++
 rtl/approx_mul_pipe_if.sv | 31 +++
 rtl/approx_ppm_reduce.sv | 53 +++++
 rtl/approx_mul_pipe.sv | 129 ++++++++++++
 tb/tb_approx_mul_pipe.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/approx_mul_pkg.sv
// -----------------------------------------------------------------------------
// approx_mul_pkg
// Shared definitions for the pipelined approximate multiplier:
//   MODE_EXACT / MODE_APPROX : per-beat mode encoding
//   pp_col_height()          : number of partial-product bits in column c
//   approx_prod()            : reference value of an approximate product
// -----------------------------------------------------------------------------
package approx_mul_pkg;

   localparam logic MODE_EXACT  = 1'b0;
   localparam logic MODE_APPROX = 1'b1;

   // Height of column c in a width x width partial-product matrix.
   function automatic int pp_col_height(input int c, input int width);
      int h;
      if ((c < 32'sd0) || (c > ((32'sd2 * width) - 32'sd2))) begin
         h = 32'sd0;
      end else if (c < width) begin
         h = c + 32'sd1;
      end else begin
         h = (32'sd2 * width) - 32'sd1 - c;
      end
      return h;
   endfunction

   // Approximate product: OR-reduced low columns (no carries between them),
   // OR of column k-1 injected at weight 2^k, exact column sums above.
   function automatic longint unsigned approx_prod(input longint unsigned a,
                                                   input longint unsigned b,
                                                   input int k,
                                                   input int width);
      longint unsigned acc;
      longint unsigned bit_v;
      int n;
      acc = 64'd0;
      for (int c = 0; c <= ((32'sd2 * width) - 32'sd2); c++) begin
         n = 32'sd0;
         for (int i = 0; i < width; i++) begin
            if (((c - i) >= 32'sd0) && ((c - i) < width)) begin
               bit_v = ((a >> (c - i)) & (b >> i)) & 64'd1;
               n     = n + int'(bit_v);
            end else begin
               n = n;
            end
         end
         if (c < k) begin
            if (n > 32'sd0) begin
               acc = acc | (64'd1 << c);
               if (c == (k - 32'sd1)) begin
                  acc = acc + (64'd1 << k);
               end else begin
                  acc = acc;
               end
            end else begin
               acc = acc;
            end
         end else begin
            acc = acc + (longint'(n) << c);
         end
      end
      return acc;
   endfunction

endpackage

// File: rtl/approx_mul_pipe_if.sv
// -----------------------------------------------------------------------------
// approx_mul_pipe_if
// Operand and product valid/ready channels of approx_mul_pipe.
//   in_valid/in_ready/in_a/in_b/in_mode       : operand beat
//   out_valid/out_ready/out_prod/out_mode     : product beat
// master = the side that produces operands and consumes products,
// slave  = the multiplier.
// -----------------------------------------------------------------------------
interface approx_mul_pipe_if #(
   parameter int WIDTH = 8
) ();
   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     in_a;
   logic [WIDTH-1:0]     in_b;
   logic                 in_mode;
   logic                 out_valid;
   logic                 out_ready;
   logic [2*WIDTH-1:0]   out_prod;
   logic                 out_mode;

   modport master (
      output in_valid, in_a, in_b, in_mode, out_ready,
      input  in_ready, out_valid, out_prod, out_mode
   );

   modport slave (
      input  in_valid, in_a, in_b, in_mode, out_ready,
      output in_ready, out_valid, out_prod, out_mode
   );
endinterface

// File: rtl/approx_ppm_reduce.sv
// -----------------------------------------------------------------------------
// approx_ppm_reduce
// Combinational partial-product matrix and reduction.
//   a, b       : unsigned operands
//   exact_prod : a*b
//   high       : sum over columns c >= K of popcount(column c) * 2^c
//   carry_k    : OR of column K-1 (to be added at weight 2^K)
//   low        : per-column OR of columns 0..K-1, no carries between them
// -----------------------------------------------------------------------------
module approx_ppm_reduce
   import approx_mul_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int K     = 7
) (
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic [2*WIDTH-1:0] exact_prod,
   output logic [2*WIDTH-1:0] high,
   output logic               carry_k,
   output logic [K-1:0]       low
);
   localparam int PW   = 2 * WIDTH;
   localparam int NCOL = 2 * WIDTH - 1;

   // col_bits_s[c][i] = a[c-i] & b[i]; positions outside the matrix are 0
   logic [NCOL-1:0][WIDTH-1:0] col_bits_s;

   for (genvar c = 0; c < NCOL; c++) begin : g_col
      for (genvar i = 0; i < WIDTH; i++) begin : g_row
         if (((c - i) >= 0) && ((c - i) < WIDTH)) begin : g_pp
            assign col_bits_s[c][i] = a[c-i] & b[i];
         end else begin : g_pad
            assign col_bits_s[c][i] = 1'b0;
         end
      end
   end

   assign exact_prod = PW'(a) * PW'(b);
   assign carry_k    = |col_bits_s[K-1];

   // Column reduction: OR for the low columns, weighted popcount above
   always_comb begin
      high = '0;
      low  = '0;
      for (int c = 0; c < K; c++) begin
         low[c] = |col_bits_s[c];
      end
      for (int c = K; c < NCOL; c++) begin
         high = high + (PW'($countones(col_bits_s[c])) << c);
      end
   end
endmodule

// File: rtl/approx_mul_pipe.sv
// -----------------------------------------------------------------------------
// approx_mul_pipe
// Three-stage pipelined exact/approximate unsigned multiplier.
//   CLK, RST_N  : clock, asynchronous active-low reset
//   bus (slave) : operand and product valid/ready channels
//   cnt_clr     : synchronous clear of approx_cnt (wins over an increment)
//   approx_cnt  : saturating count of delivered approximate products
// S1 holds operands, S2 the reduced value (plus the low OR vector in
// approximate mode), S3 the final product. in_ready is combinational from
// out_ready through the stage-enable chain.
// -----------------------------------------------------------------------------
module approx_mul_pipe
   import approx_mul_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int APPROX_COLS = 7,
   parameter int CNT_W       = 16
) (
   input  logic             CLK,
   input  logic             RST_N,
   approx_mul_pipe_if.slave bus,
   input  logic             cnt_clr,
   output logic [CNT_W-1:0] approx_cnt
);
   localparam int PW = 2 * WIDTH;
   localparam int K  = APPROX_COLS;

   // Stage registers
   logic             v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
   logic [WIDTH-1:0] a1_q, a1_d, b1_q, b1_d;
   logic             m1_q, m1_d, m2_q, m2_d, m3_q, m3_d;
   logic [PW-1:0]    red2_q, red2_d;
   logic [K-1:0]     low2_q, low2_d;
   logic [PW-1:0]    prod3_q, prod3_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Combinational
   logic             en1_s, en2_s, en3_s;
   logic             ld1_s, ld2_s, ld3_s, inc_s;
   logic [PW-1:0]    exact_s, high_s, red_appx_s;
   logic             carry_s;
   logic [K-1:0]     low_s;

   approx_ppm_reduce #(
      .WIDTH (WIDTH),
      .K     (K)
   ) u_reduce (
      .a          (a1_q),
      .b          (b1_q),
      .exact_prod (exact_s),
      .high       (high_s),
      .carry_k    (carry_s),
      .low        (low_s)
   );

   assign bus.in_ready  = en1_s;
   assign bus.out_valid = v3_q;
   assign bus.out_prod  = prod3_q;
   assign bus.out_mode  = m3_q;
   assign approx_cnt    = cnt_q;

   // Stage enables, next-state for all stages and the counter
   always_comb begin
      // a stage may take new data when empty or when its content moves on
      en3_s = ~v3_q | bus.out_ready;
      en2_s = ~v2_q | en3_s;
      en1_s = ~v1_q | en2_s;

      // data registers load only when a valid beat enters them
      ld1_s = en1_s & bus.in_valid;
      ld2_s = en2_s & v1_q;
      ld3_s = en3_s & v2_q;

      v1_d = en1_s ? bus.in_valid : v1_q;
      a1_d = ld1_s ? bus.in_a     : a1_q;
      b1_d = ld1_s ? bus.in_b     : b1_q;
      m1_d = ld1_s ? bus.in_mode  : m1_q;

      red_appx_s = high_s + (PW'(carry_s) << K);
      v2_d   = en2_s ? v1_q : v2_q;
      m2_d   = ld2_s ? m1_q : m2_q;
      red2_d = ld2_s ? ((m1_q == MODE_EXACT) ? exact_s : red_appx_s) : red2_q;
      low2_d = ld2_s ? ((m1_q == MODE_EXACT) ? {K{1'b0}} : low_s) : low2_q;

      v3_d    = en3_s ? v2_q : v3_q;
      m3_d    = ld3_s ? m2_q : m3_q;
      prod3_d = ld3_s ? (red2_q + PW'(low2_q)) : prod3_q;

      inc_s = v3_q & bus.out_ready & (m3_q == MODE_APPROX);
      if (cnt_clr) begin
         cnt_d = '0;
      end else if (inc_s && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1'b1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Pipeline and counter state; reset discards every in-flight beat
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         v1_q    <= 1'b0;
         v2_q    <= 1'b0;
         v3_q    <= 1'b0;
         a1_q    <= '0;
         b1_q    <= '0;
         m1_q    <= MODE_EXACT;
         m2_q    <= MODE_EXACT;
         m3_q    <= MODE_EXACT;
         red2_q  <= '0;
         low2_q  <= '0;
         prod3_q <= '0;
         cnt_q   <= '0;
      end else begin
         v1_q    <= v1_d;
         v2_q    <= v2_d;
         v3_q    <= v3_d;
         a1_q    <= a1_d;
         b1_q    <= b1_d;
         m1_q    <= m1_d;
         m2_q    <= m2_d;
         m3_q    <= m3_d;
         red2_q  <= red2_d;
         low2_q  <= low2_d;
         prod3_q <= prod3_d;
         cnt_q   <= cnt_d;
      end
   end
endmodule

// File: tb/tb_approx_mul_pipe.sv
// -----------------------------------------------------------------------------
// tb_approx_mul_pipe
// dut0: default parameters, directed tests.
// dut1: CNT_W = 2, driven with exactly the same stimulus as dut0 (counter
//       saturation).
// dut2: WIDTH = 12, K = 10, random operands/modes with random out_ready.
// Expected products come from model_prod(), a column-count evaluation of the
// product rules, pinned against hand-computed literals.
// -----------------------------------------------------------------------------
module tb_approx_mul_pipe;
   import approx_mul_pkg::*;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b1;
   logic        cnt_clr;
   logic [15:0] cnt0;
   logic [1:0]  cnt1;
   logic [15:0] cnt2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   approx_mul_pipe_if #(.WIDTH(8))  bus0 ();
   approx_mul_pipe_if #(.WIDTH(8))  bus1 ();
   approx_mul_pipe_if #(.WIDTH(12)) bus2 ();

   assign bus1.in_valid  = bus0.in_valid;
   assign bus1.in_a      = bus0.in_a;
   assign bus1.in_b      = bus0.in_b;
   assign bus1.in_mode   = bus0.in_mode;
   assign bus1.out_ready = bus0.out_ready;

   approx_mul_pipe #(.WIDTH(8), .APPROX_COLS(7), .CNT_W(16)) dut0 (
      .CLK(clk), .RST_N(rst_n), .bus(bus0), .cnt_clr(cnt_clr), .approx_cnt(cnt0));
   approx_mul_pipe #(.WIDTH(8), .APPROX_COLS(7), .CNT_W(2)) dut1 (
      .CLK(clk), .RST_N(rst_n), .bus(bus1), .cnt_clr(cnt_clr), .approx_cnt(cnt1));
   approx_mul_pipe #(.WIDTH(12), .APPROX_COLS(10), .CNT_W(16)) dut2 (
      .CLK(clk), .RST_N(rst_n), .bus(bus2), .cnt_clr(cnt_clr), .approx_cnt(cnt2));

   task automatic check(input string name, input longint unsigned got, input longint unsigned exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   // Counts the bits of every column, then applies the product rules.
   function automatic longint unsigned model_prod(input longint unsigned a, input longint unsigned b,
                                                  input logic mode, input int w, input int k);
      int cnt [64];
      longint unsigned r = 0;
      if (mode == MODE_EXACT) return a * b;
      for (int c = 0; c < 64; c++) cnt[c] = 0;
      for (int i = 0; i < w; i++)
         for (int j = 0; j < w; j++)
            if (((a >> j) & 1) == 1 && ((b >> i) & 1) == 1) cnt[i + j]++;
      for (int c = 0; c < 2 * w - 1; c++) begin
         if (c >= k) r += longint'(cnt[c]) * (64'd1 << c);
         else if (cnt[c] > 0) r += (64'd1 << c);
      end
      if (cnt[k - 1] > 0) r += (64'd1 << k);
      return r;
   endfunction

   // ---------------- scoreboard and per-cycle comparison ----------------
   typedef struct { longint unsigned prod; logic mode; } exp_t;
   exp_t q0[$];
   exp_t q2[$];
   int del0 = 0;
   int del2 = 0;
   logic hold0 = 1'b0, hold2 = 1'b0;
   longint unsigned hold0_prod, hold2_prod;
   logic hold0_mode, hold2_mode;

   always @(negedge clk) begin
      if (!rst_n) begin
         q0.delete();
         q2.delete();
         hold0 <= 1'b0;
         hold2 <= 1'b0;
      end else begin
         if (hold0) begin
            check("hold0_valid", 64'(bus0.out_valid), 64'd1);
            check("hold0_prod", 64'(bus0.out_prod), hold0_prod);
            check("hold0_mode", 64'(bus0.out_mode), 64'(hold0_mode));
         end
         if (bus0.out_valid && bus0.out_ready) begin
            if (q0.size() == 0) begin
               check("unexpected_beat0", 64'(bus0.out_valid), 64'd0);
            end else begin
               check("prod0", 64'(bus0.out_prod), q0[0].prod);
               check("mode0", 64'(bus0.out_mode), 64'(q0[0].mode));
               void'(q0.pop_front());
               del0 <= del0 + 1;
            end
         end
         if (bus0.in_valid && bus0.in_ready)
            q0.push_back('{prod: model_prod(64'(bus0.in_a), 64'(bus0.in_b), bus0.in_mode, 8, 7),
                           mode: bus0.in_mode});
         hold0      <= bus0.out_valid && !bus0.out_ready;
         hold0_prod <= 64'(bus0.out_prod);
         hold0_mode <= bus0.out_mode;

         if (hold2) begin
            check("hold2_prod", 64'(bus2.out_prod), hold2_prod);
            check("hold2_mode", 64'(bus2.out_mode), 64'(hold2_mode));
         end
         if (bus2.out_valid && bus2.out_ready) begin
            if (q2.size() == 0) begin
               check("unexpected_beat2", 64'(bus2.out_valid), 64'd0);
            end else begin
               check("prod2", 64'(bus2.out_prod), q2[0].prod);
               check("mode2", 64'(bus2.out_mode), 64'(q2[0].mode));
               void'(q2.pop_front());
               del2 <= del2 + 1;
            end
         end
         if (bus2.in_valid && bus2.in_ready)
            q2.push_back('{prod: model_prod(64'(bus2.in_a), 64'(bus2.in_b), bus2.in_mode, 12, 10),
                           mode: bus2.in_mode});
         hold2      <= bus2.out_valid && !bus2.out_ready;
         hold2_prod <= 64'(bus2.out_prod);
         hold2_mode <= bus2.out_mode;
      end
   end

   // ---------------- drivers ----------------
   task automatic send0(input logic [7:0] a, input logic [7:0] b, input logic m);
      int g = 0;
      bus0.in_a = a; bus0.in_b = b; bus0.in_mode = m; bus0.in_valid = 1'b1;
      @(negedge clk);
      while (!bus0.in_ready && g < 50) begin @(negedge clk); g++; end
      if (g >= 50) check("send0_timeout", 64'(g), 64'd0);
      @(posedge clk); #1;
      bus0.in_valid = 1'b0;
   endtask

   task automatic send2(input logic [11:0] a, input logic [11:0] b, input logic m);
      int g = 0;
      bus2.in_a = a; bus2.in_b = b; bus2.in_mode = m; bus2.in_valid = 1'b1;
      @(negedge clk);
      while (!bus2.in_ready && g < 50) begin @(negedge clk); g++; end
      if (g >= 50) check("send2_timeout", 64'(g), 64'd0);
      @(posedge clk); #1;
      bus2.in_valid = 1'b0;
   endtask

   task automatic drain0();
      int g = 0;
      while ((q0.size() != 0 || bus0.out_valid) && g < 100) begin @(posedge clk); #1; g++; end
      check("drain0", 64'(q0.size()), 64'd0);
   endtask

   task automatic drain2();
      int g = 0;
      while ((q2.size() != 0 || bus2.out_valid) && g < 100) begin @(posedge clk); #1; g++; end
      check("drain2", 64'(q2.size()), 64'd0);
   endtask

   // ---------------- directed sequence ----------------
   logic done2 = 1'b0;

   initial begin
      int lat;
      int g;
      int base;
      bus0.in_valid = 1'b0; bus0.in_a = '0; bus0.in_b = '0; bus0.in_mode = 1'b0; bus0.out_ready = 1'b1;
      bus2.in_valid = 1'b0; bus2.in_a = '0; bus2.in_b = '0; bus2.in_mode = 1'b0; bus2.out_ready = 1'b1;
      cnt_clr = 1'b0;

      // hand-computed values pin the model and the package reference
      check("model_ax_255", model_prod(64'd255, 64'd255, MODE_APPROX, 8, 7), 64'd64511);
      check("model_ex_255", model_prod(64'd255, 64'd255, MODE_EXACT, 8, 7), 64'd65025);
      check("model_ax_3", model_prod(64'd3, 64'd3, MODE_APPROX, 8, 7), 64'd7);
      check("model_ex_3", model_prod(64'd3, 64'd3, MODE_EXACT, 8, 7), 64'd9);
      check("model_ax_80", model_prod(64'd128, 64'd128, MODE_APPROX, 8, 7), 64'd16384);
      check("pkg_ax_255", approx_prod(64'd255, 64'd255, 7, 8), 64'd64511);
      check("pkg_ax_3", approx_prod(64'd3, 64'd3, 7, 8), 64'd7);
      check("pkg_col_h", 64'(pp_col_height(7, 8)), 64'd8);

      // reset state
      #1 rst_n = 1'b0;
      #3;
      check("rst_out_valid", 64'(bus0.out_valid), 64'd0);
      check("rst_out_prod", 64'(bus0.out_prod), 64'd0);
      check("rst_out_mode", 64'(bus0.out_mode), 64'd0);
      check("rst_cnt", 64'(cnt0), 64'd0);
      @(posedge clk); @(posedge clk); #7;
      rst_n = 1'b1;
      #1;
      check("rst_in_ready", 64'(bus0.in_ready), 64'd1);
      @(posedge clk); #1;

      // latency: the beat passes S1, S2, S3 and is on the output in the third cycle
      send0(8'd255, 8'd255, MODE_APPROX);
      lat = 0;
      while (!bus0.out_valid && lat < 10) begin @(negedge clk); lat++; end
      check("latency", 64'(lat), 64'd3);
      check("first_prod", 64'(bus0.out_prod), 64'd64511);
      @(posedge clk); #1;

      // back-to-back directed vectors, exact and approximate mixed
      send0(8'd255, 8'd255, MODE_EXACT);
      send0(8'd3, 8'd3, MODE_APPROX);
      send0(8'd3, 8'd3, MODE_EXACT);
      send0(8'h80, 8'h80, MODE_APPROX);
      send0(8'hA5, 8'h5A, MODE_APPROX);
      drain0();

      // stall: out_ready low in stream cycles 2..6
      base = del0;
      fork
         begin
            for (int k = 0; k < 10; k++) send0(8'(k * 23 + 5), 8'(k * 11 + 7), (k % 2 == 1));
         end
         begin
            for (int k = 0; k < 12; k++) begin
               bus0.out_ready = !(k >= 2 && k <= 6);
               @(negedge clk);
               if (k == 6) begin
                  check("stall_in_ready", 64'(bus0.in_ready), 64'd0);
                  check("stall_buffered", 64'(q0.size()), 64'd3);
                  check("stall_out_valid", 64'(bus0.out_valid), 64'd1);
               end
               if (k == 7) check("full_shift_in_ready", 64'(bus0.in_ready), 64'd1);
               @(posedge clk); #1;
            end
            bus0.out_ready = 1'b1;
         end
      join
      drain0();
      check("stream_count", 64'(del0 - base), 64'd10);

      // counter: 5 approximate among 4 exact, then clear against a 6th delivery
      cnt_clr = 1'b1;
      @(posedge clk); #1;
      cnt_clr = 1'b0;
      @(negedge clk);
      check("cnt_cleared", 64'(cnt0), 64'd0);
      check("cnt1_cleared", 64'(cnt1), 64'd0);
      @(posedge clk); #1;
      for (int k = 0; k < 9; k++)
         send0(8'(k * 29 + 1), 8'(k * 13 + 3), (k % 2 == 0) ? MODE_APPROX : MODE_EXACT);
      drain0();
      @(negedge clk);
      check("cnt_five", 64'(cnt0), 64'd5);
      check("cnt_sat", 64'(cnt1), 64'd3);
      @(posedge clk); #1;
      bus0.out_ready = 1'b0;
      send0(8'd200, 8'd100, MODE_APPROX);
      g = 0;
      while (!bus0.out_valid && g < 20) begin @(negedge clk); g++; end
      check("park_valid", 64'(bus0.out_valid), 64'd1);
      @(posedge clk); #1;
      bus0.out_ready = 1'b1;
      cnt_clr = 1'b1;
      @(negedge clk);
      check("cnt_before_clr", 64'(cnt0), 64'd5);
      @(posedge clk); #1;
      cnt_clr = 1'b0;
      @(negedge clk);
      check("cnt_clr_wins", 64'(cnt0), 64'd0);
      check("cnt1_clr_wins", 64'(cnt1), 64'd0);
      @(posedge clk); #1;

      // reset with three beats in flight
      send0(8'd17, 8'd19, MODE_APPROX);
      drain0();
      check("cnt_pre_reset", 64'(cnt0), 64'd1);
      send0(8'd21, 8'd22, MODE_APPROX);
      send0(8'd23, 8'd24, MODE_EXACT);
      send0(8'd25, 8'd26, MODE_APPROX);
      check("pre_reset_valid", 64'(bus0.out_valid), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_valid", 64'(bus0.out_valid), 64'd0);
      check("async_rst_prod", 64'(bus0.out_prod), 64'd0);
      check("async_rst_mode", 64'(bus0.out_mode), 64'd0);
      check("async_rst_cnt", 64'(cnt0), 64'd0);
      @(posedge clk); #7;
      rst_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         check("post_rst_idle", 64'(bus0.out_valid), 64'd0);
      end
      @(posedge clk); #1;

      // random sweep on the 12-bit instance
      fork
         begin
            for (int n = 0; n < 150; n++) begin
               if (n == 0) send2(12'hFFF, 12'hFFF, MODE_APPROX);
               else if (n == 1) send2(12'hFFF, 12'hFFF, MODE_EXACT);
               else if (n == 2) send2(12'h000, 12'hABC, MODE_APPROX);
               else send2(12'($urandom), 12'($urandom), 1'($urandom_range(0, 1)));
            end
            done2 = 1'b1;
         end
         begin
            while (!done2) begin
               bus2.out_ready = ($urandom_range(0, 3) != 0);
               @(posedge clk); #1;
            end
            bus2.out_ready = 1'b1;
         end
      join
      drain2();
      check("sweep_count", 64'(del2), 64'd150);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
